// File: rtl/fetch_ar_src.sv
// Instruction-fetch source: owns the fetch PC, issues in-order imem reads,
// buffers returned words and hands {inst, pc+4} to IF with valid/ready.
// A one-cycle pc_opt pulse flushes buffered and in-flight fetches and
// restarts fetching at pc_target.
module fetch_ar_src #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        AR_valid,
    output logic [31:0] AR_inst,
    output logic [31:0] PC_snpc,
    input  logic        ready,
    input  logic        pc_opt,
    input  logic [31:0] pc_target
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] snpc;
    } entry_t;

    entry_t          fifo [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [31:0]     pc;

    logic [SW-1:0]   occupancy;
    logic            req_fire;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic [31:0]     rsp_pc;
    entry_t          head_entry;

    // Handshake decode, occupancy limit and head presentation
    always_comb begin
        occupancy      = SW'(inflight) + SW'(count) + SW'(drop);
        imem_req_valid = (occupancy < SW'(DEPTH)) && !pc_opt;
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_keep       = imem_rsp_valid && (drop == '0);
        rsp_drop       = imem_rsp_valid && (drop != '0);
        push           = rsp_keep && !pc_opt;
        AR_valid       = (count != '0) && !pc_opt;
        pop            = AR_valid && ready;
        // Requests are sequential, so the oldest live request sits inflight words behind pc
        rsp_pc         = pc - (32'(inflight) << 2);
        head_entry     = fifo[head];
        AR_inst        = '0;
        PC_snpc        = '0;
        if (count != '0) begin
            AR_inst = head_entry.inst;
            PC_snpc = head_entry.snpc;
        end
    end

    // Control state: PC, FIFO pointers and outstanding-request counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else if (pc_opt) begin
            pc       <= pc_target;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            // Everything still owed by memory becomes stale; a response this cycle settles one
            drop     <= drop + inflight - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            count    <= count + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(req_fire) - CW'(rsp_keep);
            drop     <= drop - CW'(rsp_drop);
        end
    end

    // Buffer storage, written at the tail on a kept response
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[tail] <= '{inst: imem_rsp_data, snpc: rsp_pc + 32'd4};
        end
    end

    // Memory must never answer a request that was not issued
    rsp_legal: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> ((inflight != '0) || (drop != '0)));

endmodule
